// File: rtl/uart_pkg.sv
// Shared definitions for the UART transceiver: parity modes, FSM state
// encodings and the parity helper used by both TX and RX.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Widest data word the parity helper has to cover.
    localparam int PAR_MAX_W = 9;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_IDLE = 3'd5
    } rx_state_e;

    // Parity bit that makes data+parity even (mode EVEN) or odd (mode ODD).
    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [PAR_MAX_W-1:0] data, input int mode);
        logic p;
        p = ^data;
        if (mode == PARITY_ODD) begin
            return ~p;
        end else begin
            return p;
        end
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers carry one extra wrap
// bit so full and empty can be told apart without a separate counter.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer and storage values from the push/pop requests.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        mem_d     = mem_q;
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push_s) begin
            wr_ptr_d                   = wr_ptr_q + PTR_ONE;
            mem_d[wr_ptr_q[AW-1:0]]    = push_data;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // Pointer and storage registers; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/uart_core.sv
// UART transceiver: byte-wide valid/ready host side with a FIFO in each
// direction, serial txd/rxd line side, and one-cycle error pulses for
// framing, parity and overrun conditions.
module uart_core
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] send_data,
    input  logic              send_valid,
    output logic              send_ready,
    output logic [DATA_W-1:0] recv_data,
    output logic              recv_valid,
    input  logic              recv_ready,
    input  logic              rxd,
    output logic              txd,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ONE  = {{(BIT_W-1){1'b0}}, 1'b1};
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic             PAR_EN    = (PARITY != PARITY_NONE) ? 1'b1 : 1'b0;

    // ------------------------------------------------------------------
    // FIFOs
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] tx_head_s;
    logic              tx_full_s, tx_empty_s, tx_pop_s, tx_push_s;
    logic              rx_full_s, rx_empty_s;

    // Gate the push with ready so a same-cycle pop of a full FIFO never
    // takes a word the host believes was refused.
    assign tx_push_s  = send_valid && !tx_full_s;
    assign send_ready = !tx_full_s;
    assign recv_valid = !rx_empty_s;

    uart_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_push_s),
        .push_data (send_data),
        .pop       (tx_pop_s),
        .pop_data  (tx_head_s),
        .full      (tx_full_s),
        .empty     (tx_empty_s)
    );

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_e         tx_state_q, tx_state_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_shreg_q, tx_shreg_d;
    logic              tx_par_q, tx_par_d;
    logic              tx_stop_q, tx_stop_d;
    logic              txd_q, txd_d;
    logic [PAR_MAX_W-1:0] tx_head_ext_s;

    assign txd = txd_q;

    // TX next state: txd_d is the line level for the bit entered at the next edge.
    always_comb begin
        tx_state_d    = tx_state_q;
        tx_cnt_d      = tx_cnt_q;
        tx_bit_d      = tx_bit_q;
        tx_shreg_d    = tx_shreg_q;
        tx_par_d      = tx_par_q;
        tx_stop_d     = tx_stop_q;
        txd_d         = txd_q;
        tx_pop_s      = 1'b0;
        tx_head_ext_s = {PAR_MAX_W{1'b0}};
        tx_head_ext_s[DATA_W-1:0] = tx_head_s;

        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_shreg_d = tx_head_s;
                    tx_par_d   = parity_bit(tx_head_ext_s, PARITY);
                    tx_cnt_d   = CNT_ZERO;
                    tx_state_d = TX_START;
                    txd_d      = 1'b0;
                end else begin
                    txd_d = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = CNT_ZERO;
                    tx_bit_d   = BIT_ZERO;
                    tx_state_d = TX_DATA;
                    txd_d      = tx_shreg_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = CNT_ZERO;
                    if (tx_bit_q == BIT_LAST) begin
                        if (PAR_EN) begin
                            tx_state_d = TX_PARITY;
                            txd_d      = tx_par_q;
                        end else begin
                            tx_state_d = TX_STOP;
                            tx_stop_d  = 1'b0;
                            txd_d      = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + BIT_ONE;
                        tx_shreg_d = {1'b0, tx_shreg_q[DATA_W-1:1]};
                        txd_d      = tx_shreg_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            TX_PARITY: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = CNT_ZERO;
                    tx_stop_d  = 1'b0;
                    tx_state_d = TX_STOP;
                    txd_d      = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = CNT_ZERO;
                    if (tx_stop_q == STOP_LAST) begin
                        // Chain straight into the next start bit when more data is queued.
                        if (!tx_empty_s) begin
                            tx_pop_s   = 1'b1;
                            tx_shreg_d = tx_head_s;
                            tx_par_d   = parity_bit(tx_head_ext_s, PARITY);
                            tx_state_d = TX_START;
                            txd_d      = 1'b0;
                        end else begin
                            tx_state_d = TX_IDLE;
                            txd_d      = 1'b1;
                        end
                    end else begin
                        tx_stop_d = 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                txd_d      = 1'b1;
            end
        endcase
    end

    // TX state registers; reset drives the line idle high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= CNT_ZERO;
            tx_bit_q   <= BIT_ZERO;
            tx_shreg_q <= {DATA_W{1'b0}};
            tx_par_q   <= 1'b0;
            tx_stop_q  <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shreg_q <= tx_shreg_d;
            tx_par_q   <= tx_par_d;
            tx_stop_q  <= tx_stop_d;
            txd_q      <= txd_d;
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_e         rx_state_q, rx_state_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]  rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_shreg_q, rx_shreg_d;
    logic              rx_par_q, rx_par_d;
    logic              rx_push_q, rx_push_d;
    logic              rxd_s1_q, rxd_s2_q, rxd_prev_q;
    logic              frame_err_q, frame_err_d;
    logic              parity_err_q, parity_err_d;
    logic              overrun_q, overrun_d;
    logic [PAR_MAX_W-1:0] rx_word_ext_s;

    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

    uart_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push_q),
        .push_data (rx_shreg_q),
        .pop       (recv_ready),
        .pop_data  (recv_data),
        .full      (rx_full_s),
        .empty     (rx_empty_s)
    );

    // Two-flop synchronizer plus a delayed copy for start-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_s1_q   <= rxd;
            rxd_s2_q   <= rxd_s1_q;
            rxd_prev_q <= rxd_s2_q;
        end
    end

    // RX next state: half-bit to the start centre, then one sample per bit period.
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_bit_d      = rx_bit_q;
        rx_shreg_d    = rx_shreg_q;
        rx_par_d      = rx_par_q;
        rx_push_d     = 1'b0;
        frame_err_d   = 1'b0;
        parity_err_d  = 1'b0;
        overrun_d     = rx_push_q && rx_full_s && !recv_ready;
        rx_word_ext_s = {PAR_MAX_W{1'b0}};
        rx_word_ext_s[DATA_W-1:0] = rx_shreg_q;

        case (rx_state_q)
            RX_IDLE: begin
                if (rxd_prev_q && !rxd_s2_q) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_state_d = RX_START;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d = CNT_ZERO;
                    // A line back high at mid-start is a glitch, not a frame.
                    if (rxd_s2_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_bit_d   = BIT_ZERO;
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_shreg_d = {rxd_s2_q, rx_shreg_q[DATA_W-1:1]};
                    if (rx_bit_q == BIT_LAST) begin
                        if (PAR_EN) begin
                            rx_state_d = RX_PARITY;
                        end else begin
                            rx_state_d = RX_STOP;
                        end
                    end else begin
                        rx_bit_d = rx_bit_q + BIT_ONE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_PARITY: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_par_d   = rxd_s2_q;
                    rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d = CNT_ZERO;
                    // A bad stop bit takes priority over a parity mismatch.
                    if (!rxd_s2_q) begin
                        frame_err_d = 1'b1;
                        rx_state_d  = RX_WAIT_IDLE;
                    end else if (PAR_EN && (rx_par_q != parity_bit(rx_word_ext_s, PARITY))) begin
                        parity_err_d = 1'b1;
                        rx_state_d   = RX_IDLE;
                    end else begin
                        rx_push_d  = 1'b1;
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_WAIT_IDLE: begin
                if (rxd_s2_q) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_WAIT_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // RX state and error-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= CNT_ZERO;
            rx_bit_q     <= BIT_ZERO;
            rx_shreg_q   <= {DATA_W{1'b0}};
            rx_par_q     <= 1'b0;
            rx_push_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shreg_q   <= rx_shreg_d;
            rx_par_q     <= rx_par_d;
            rx_push_q    <= rx_push_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: a default instance (optionally looped back)
// and a PARITY=1 instance with its own rxd driver.
module tb_uart_core;

    localparam int CLK_DIV = 16;

    logic       clk = 1'b0;
    logic       rst_n;

    // Default-parameter instance
    logic [7:0] send_data;
    logic       send_valid;
    logic       send_ready;
    logic [7:0] recv_data;
    logic       recv_valid;
    logic       recv_ready;
    logic       rxd;
    logic       txd;
    logic       frame_err, parity_err, overrun;
    logic       rxd_drv;
    logic       loop_en;

    // Even-parity instance
    logic [7:0] send_data_p;
    logic       send_valid_p;
    logic       send_ready_p;
    logic [7:0] recv_data_p;
    logic       recv_valid_p;
    logic       recv_ready_p;
    logic       rxd_p;
    logic       txd_p;
    logic       frame_err_p, parity_err_p, overrun_p;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
    int fe_cnt_p = 0, pe_cnt_p = 0, ov_cnt_p = 0;

    assign rxd = loop_en ? txd : rxd_drv;

    always #5 clk = ~clk;

    uart_core u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .send_data  (send_data),
        .send_valid (send_valid),
        .send_ready (send_ready),
        .recv_data  (recv_data),
        .recv_valid (recv_valid),
        .recv_ready (recv_ready),
        .rxd        (rxd),
        .txd        (txd),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    uart_core #(.PARITY(1)) u_dut_p (
        .clk        (clk),
        .rst_n      (rst_n),
        .send_data  (send_data_p),
        .send_valid (send_valid_p),
        .send_ready (send_ready_p),
        .recv_data  (recv_data_p),
        .recv_valid (recv_valid_p),
        .recv_ready (recv_ready_p),
        .rxd        (rxd_p),
        .txd        (txd_p),
        .frame_err  (frame_err_p),
        .parity_err (parity_err_p),
        .overrun    (overrun_p)
    );

    // Count high cycles of every error output (one per cycle, so a pulse counts 1).
    always @(negedge clk) begin
        fe_cnt   <= fe_cnt   + int'(frame_err);
        pe_cnt   <= pe_cnt   + int'(parity_err);
        ov_cnt   <= ov_cnt   + int'(overrun);
        fe_cnt_p <= fe_cnt_p + int'(frame_err_p);
        pe_cnt_p <= pe_cnt_p + int'(parity_err_p);
        ov_cnt_p <= ov_cnt_p + int'(overrun_p);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer one word; returns at the negedge after the accepting edge.
    task automatic send(input bit p, input logic [7:0] d);
        int t;
        t = 0;
        while (!(p ? send_ready_p : send_ready) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) check("send_ready_timeout", 32'd0, 32'd1);
        if (p) begin
            send_data_p = d; send_valid_p = 1'b1;
        end else begin
            send_data = d; send_valid = 1'b1;
        end
        @(negedge clk);
        send_valid   = 1'b0;
        send_valid_p = 1'b0;
    endtask

    task automatic wait_valid(input bit p, input int max, output int n);
        n = 0;
        while (!(p ? recv_valid_p : recv_valid) && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pop(input bit p, input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(p ? recv_valid_p : recv_valid), 32'd1);
        check(tag, 32'(p ? recv_data_p : recv_data), 32'(exp));
        if (p) recv_ready_p = 1'b1; else recv_ready = 1'b1;
        @(negedge clk);
        recv_ready   = 1'b0;
        recv_ready_p = 1'b0;
    endtask

    task automatic drive_bit(input bit p, input logic v);
        if (p) rxd_p = v; else rxd_drv = v;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    // Drive one 8-bit frame on the chosen rxd, then leave the line idle.
    task automatic drive_frame(input bit p, input logic [7:0] d, input bit par_en,
                               input logic par, input logic stop);
        drive_bit(p, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(p, d[i]);
        if (par_en) drive_bit(p, par);
        drive_bit(p, stop);
        if (p) rxd_p = 1'b1; else rxd_drv = 1'b1;
    endtask

    logic [9:0] frm;
    int         n, ones, lat;
    int         fe0, pe0, ov0;

    initial begin
        rst_n = 1'b0;
        send_data = 8'h00; send_valid = 1'b0; recv_ready = 1'b0;
        send_data_p = 8'h00; send_valid_p = 1'b0; recv_ready_p = 1'b0;
        rxd_drv = 1'b1; rxd_p = 1'b1; loop_en = 1'b0;
        tick(3);
        check("rst_txd",        32'(txd),        32'd1);
        check("rst_send_ready", 32'(send_ready), 32'd1);
        check("rst_recv_valid", 32'(recv_valid), 32'd0);
        check("rst_recv_data",  32'(recv_data),  32'h0);
        check("rst_errs",       32'({frame_err, parity_err, overrun}), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // 1: 0xA5 on the line, bit by bit.
        send(1'b0, 8'hA5);
        check("tx_send_ready", 32'(send_ready), 32'd1);
        frm = {1'b1, 8'hA5, 1'b0};
        for (int b = 0; b < 10; b++) begin
            ones = 0;
            for (int c = 0; c < CLK_DIV; c++) begin
                @(negedge clk);
                if (txd == frm[b]) ones++;
            end
            check($sformatf("tx_a5_bit%0d", b), 32'(ones), 32'd16);
        end
        tick(5);
        check("tx_idle_after", 32'(txd), 32'd1);

        // 2: loopback of two back-to-back words.
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
        loop_en = 1'b1;
        send(1'b0, 8'h3C);
        send(1'b0, 8'hC3);
        wait_valid(1'b0, 400, n);
        lat = n + 1;
        check("lb_latency_window", 32'(lat >= 152 && lat <= 168), 32'd1);
        pop(1'b0, "lb_word0", 8'h3C);
        wait_valid(1'b0, 400, n);
        pop(1'b0, "lb_word1", 8'hC3);
        tick(20);
        check("lb_empty", 32'(recv_valid), 32'd0);
        check("lb_no_errs", 32'((fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0)), 32'd0);
        loop_en = 1'b0;

        // 3: even parity; 0x07 has three ones so the parity bit is 1.
        send(1'b1, 8'h07);
        tick(24);  check("p_tx_d0",     32'(txd_p), 32'd1);
        tick(48);  check("p_tx_d3",     32'(txd_p), 32'd0);
        tick(80);  check("p_tx_parity", 32'(txd_p), 32'd1);
        tick(16);  check("p_tx_stop",   32'(txd_p), 32'd1);
        tick(20);
        pe0 = pe_cnt_p; fe0 = fe_cnt_p;
        drive_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        tick(6);
        check("p_bad_pulse",  32'(pe_cnt_p - pe0), 32'd1);
        check("p_bad_novalid", 32'(recv_valid_p), 32'd0);
        check("p_bad_no_fe",  32'(fe_cnt_p - fe0), 32'd0);
        tick(10);
        drive_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        tick(4);
        pop(1'b1, "p_good_07", 8'h07);
        tick(10);
        drive_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
        tick(4);
        pop(1'b1, "p_good_03", 8'h03);
        check("p_total_pe", 32'(pe_cnt_p - pe0), 32'd1);

        // 4: bad stop bit, then a good frame.
        tick(10);
        fe0 = fe_cnt; pe0 = pe_cnt;
        drive_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        tick(4);
        check("fe_pulse",   32'(fe_cnt - fe0), 32'd1);
        check("fe_no_push", 32'(recv_valid),   32'd0);
        check("fe_no_pe",   32'(pe_cnt - pe0), 32'd0);
        tick(20);
        drive_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
        tick(4);
        pop(1'b0, "fe_then_12", 8'h12);

        // 5: overrun on the fifth looped word with nobody popping.
        tick(10);
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
        loop_en = 1'b1;
        for (int i = 1; i <= 5; i++) send(1'b0, 8'(i));
        tick(1100);
        loop_en = 1'b0;
        check("ov_pulse", 32'(ov_cnt - ov0), 32'd1);
        check("ov_no_other", 32'((fe_cnt - fe0) + (pe_cnt - pe0)), 32'd0);
        for (int i = 1; i <= 4; i++) pop(1'b0, $sformatf("ov_pop%0d", i), 8'(i));
        check("ov_drained", 32'(recv_valid), 32'd0);

        // 6a: short low glitch is a false start.
        tick(10);
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
        rxd_drv = 1'b0; tick(6); rxd_drv = 1'b1;
        tick(40);
        check("glitch_novalid", 32'(recv_valid), 32'd0);
        check("glitch_no_errs", 32'((fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0)), 32'd0);

        // 6b: reset mid-transmit with words queued in both FIFOs.
        drive_frame(1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
        tick(4);
        check("pre_rst_rx_word", 32'(recv_valid), 32'd1);
        send(1'b0, 8'h5A);
        send(1'b0, 8'h11);
        tick(8);
        check("pre_rst_txd_low", 32'(txd), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_txd_now",   32'(txd),        32'd1);
        check("rst_rx_empty",  32'(recv_valid), 32'd0);
        check("rst_rx_data",   32'(recv_data),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (txd == 1'b1) ones++;
        end
        check("post_rst_tx_quiet", 32'(ones), 32'd40);
        check("post_rst_ready",    32'(send_ready), 32'd1);
        check("post_rst_rx_empty", 32'(recv_valid), 32'd0);
        check("post_rst_no_errs",  32'((fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0)), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Synthesizable, parametrised UART transceiver for the LC3 SoC.
- Replaces the bit-level DPI helpers on the synthesizable path.
- Host side uses a byte-oriented valid/ready interface (send/recv), with FIFO buffering in each direction.
- Line side is the serial txd/rxd pins.
- Configurable data width, baud divisor, parity mode and stop-bit count.
- Adds error reporting: framing, parity and overrun.

Parameters:
- DATA_W, 8, data bits per frame, legal range 5..9.
- CLK_DIV, 16, clk cycles per serial bit; must be even and at least 4.
- FIFO_DEPTH, 4, entries per direction; must be a power of 2 and at least 2.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, stop bits per frame: 1 or 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- send_data  in  DATA_W  byte to transmit
- send_valid  in  1  send_data valid
- send_ready  out  1  TX FIFO not full
- recv_data  out  DATA_W  head of RX FIFO
- recv_valid  out  1  RX FIFO not empty
- recv_ready  in  1  consumer pops head
- rxd  in  1  serial input, asynchronous, idle high
- txd  out  1  serial output, idle high
- frame_err  out  1  one-cycle pulse: bad stop bit
- parity_err  out  1  one-cycle pulse: parity mismatch
- overrun  out  1  one-cycle pulse: RX word dropped because FIFO full

Behaviour:
- Reset (rst_n low, async, takes effect immediately):
  - txd=1, send_ready=1, recv_valid=0, recv_data=0.
  - frame_err, parity_err and overrun all 0.
  - FIFOs emptied, both FSMs to IDLE.
  - Reset mid-frame aborts the frame with no error pulse.
- Handshakes:
  - A transfer occurs on a clk edge where valid && ready.
  - send_ready = !tx_full. recv_valid = !rx_empty.
  - recv_data is first-word-fall-through and stable while recv_valid && !recv_ready.
- Frame format: start(0), DATA_W bits LSB first, optional parity, STOP_BITS ones. Every bit is exactly CLK_DIV cycles.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - In IDLE with the FIFO non-empty: pop the word, enter START.
  - If send is accepted at edge k into an empty FIFO with TX idle, txd falls after edge k+1.
  - Back-to-back words leave no idle gap between the last stop bit and the next start bit.
- RX path:
  - rxd passes through a 2-flop synchronizer (2-cycle latency); all timing is relative to the synchronized signal.
  - IDLE: a 1->0 transition enters START and counts CLK_DIV/2 cycles.
    - If the sample there is 1: false start, return to IDLE, no pulse.
  - Subsequent samples are taken every CLK_DIV cycles, at mid-bit.
  - Parity bit: even means the total count of ones over data+parity is even; odd means it is odd. On mismatch, parity_err pulses and the word is discarded.
  - Only the first stop bit is checked. If it samples 0, frame_err pulses and the word is discarded. The FSM then waits for rxd=1 before re-arming IDLE.
  - If both parity and stop bit are bad, only frame_err pulses.
  - Good word: pushed in the cycle after the stop-bit sample. Word to recv_valid high is 1 cycle.
  - RX FIFO full at push: overrun pulses, the new word is dropped, existing contents are untouched.
  - If a pop (recv_ready) happens in the same cycle as a push to a full FIFO, the push succeeds and there is no overrun.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH. full/empty are derived from the MSB comparison.
- Counters are sized $clog2(CLK_DIV) and $clog2(DATA_W+1). No overflow is possible within legal parameters.

Decomposition:
- Shared package uart_pkg:
  - PARITY_NONE/EVEN/ODD constants.
  - TX state typedef: IDLE, START, DATA, PARITY, STOP.
  - RX state typedef: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- Sub-module uart_fifo: synchronous FWFT FIFO parametrised by width and depth, instantiated once per direction.
- TX and RX FSMs stay inline in uart_core.

Test Plan:
- Defaults, send 0xA5: txd=0 for 16 cycles, then bits 1,0,1,0,0,1,0,1 (16 each), then 1 for 16; send_ready stays 1.
- txd looped to rxd, send 0x3C then 0xC3 back-to-back: recv_data 0x3C then 0xC3 in order, no error pulses; first word arrives 10*16+O(4) cycles after acceptance.
- PARITY=1, send 0x07: parity bit=1 on line. Bench drives the same frame with parity forced 0 into rxd: parity_err pulses once, recv_valid stays 0.
- Drive rxd frame 0x55 with stop bit 0: frame_err pulses for 1 cycle, no push. Then a valid frame 0x12: recv_data=0x12.
- recv_ready=0, loop back 5 bytes 0x01..0x05 with FIFO_DEPTH=4: overrun pulses once on 0x05; popping yields 0x01..0x04 and then recv_valid=0.
- rxd low for 6 cycles only: no reception, no pulses. Assert rst_n=0 mid-transmit of 0x5A: txd=1 immediately and the FIFOs are empty after reset release.
